booth_mul_unit: RTL



---
 rtl/mul_pkg.sv | 16 +
 rtl/booth_step.sv | 33 +++
 rtl/booth_mul_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// FSM encoding, Booth recoding constants and default operand width.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    localparam int MUL_WIDTH = 16;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A,
// followed by an arithmetic right shift of {A,Q,Q_m1}.
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q_m1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_m1
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = i_a;
        unique case ({i_q[0], i_q_m1})
            BOOTH_ADD: w_sum = i_a + i_m;
            BOOTH_SUB: w_sum = i_a - i_m;
            default:   w_sum = i_a;
        endcase
    end

    // A is one bit wider than the operands, so its top bit is the true sign.
    always_comb begin
        {o_a, o_q, o_q_m1} = {w_sum[WIDTH], w_sum, i_q};
    end

endmodule

// File: rtl/booth_mul_unit.sv
// Sequential radix-2 Booth signed multiplier with start/done handshake.
// Optional overflow flag output enabled by defining MUL_OVF_FLAG_EN.
module booth_mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               start,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic               ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t         r_state;
    mul_state_t         w_state_nxt;

    logic [WIDTH:0]     r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_q_m1;
    logic [WIDTH:0]     r_m;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_a_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_q_m1_nxt;
    logic [2*WIDTH-1:0] w_product_nxt;
    logic               w_last;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a    (r_a),
        .i_q    (r_q),
        .i_q_m1 (r_q_m1),
        .i_m    (r_m),
        .o_a    (w_a_nxt),
        .o_q    (w_q_nxt),
        .o_q_m1 (w_q_m1_nxt)
    );

    assign w_last        = (r_count == LAST);
    assign w_product_nxt = {w_a_nxt[WIDTH-1:0], w_q_nxt};

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = STEP;
            STEP:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= {x_in[WIDTH-1], x_in};
                        r_q     <= y_in;
                        r_a     <= '0;
                        r_q_m1  <= 1'b0;
                        r_count <= '0;
                    end
                end
                STEP: begin
                    r_a     <= w_a_nxt;
                    r_q     <= w_q_nxt;
                    r_q_m1  <= w_q_m1_nxt;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_product <= w_product_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MUL_OVF_FLAG_EN
    logic [WIDTH:0] w_hi;
    logic           w_ovf_nxt;
    logic           r_ovf;

    // Fits in WIDTH signed bits only if the top WIDTH+1 bits agree.
    assign w_hi      = w_product_nxt[2*WIDTH-1:WIDTH-1];
    assign w_ovf_nxt = ~((&w_hi) | ~(|w_hi));

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_ovf <= 1'b0;
        end else if (r_state == STEP && w_last) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule
